// File: rtl/sn_prot_arbiter.sv
`default_nettype none
// sn_prot_arbiter -- round-robin arbiter with a bounded bus lock in front of the sn_network
// single-register protocol bus. One registered issue stage; done/read data follow one cycle later. Rev 1.0
module sn_prot_arbiter #(
  parameter int P_NUM_REQ      = 2,
  parameter int P_ADDR_BW      = 7,
  parameter int P_DATA_BW      = 8,
  parameter int P_MAX_HOLD     = 16,
  parameter int P_LOCK_TIMEOUT = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [P_NUM_REQ-1:0]                req_valid,
  input  logic [P_NUM_REQ-1:0]                req_lock,
  input  logic [P_NUM_REQ-1:0]                req_r0w1,
  input  logic [P_NUM_REQ-1:0][P_ADDR_BW-1:0] req_addr,
  input  logic [P_NUM_REQ-1:0][P_DATA_BW-1:0] req_wdata,
  output logic [P_NUM_REQ-1:0]                req_ready,
  output logic [P_NUM_REQ-1:0]                req_done,
  output logic [P_DATA_BW-1:0]                req_rdata,
  output logic                                prot_enable,
  output logic                                prot_r0w1,
  output logic [P_ADDR_BW-1:0]                prot_addr,
  output logic [P_DATA_BW-1:0]                prot_wdata,
  input  logic [P_DATA_BW-1:0]                prot_rdata
);

  localparam int IDX_W  = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int HOLD_W = (P_MAX_HOLD > 2) ? $clog2(P_MAX_HOLD) : 1;
  localparam int IDLE_W = $clog2(P_LOCK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(P_NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(P_MAX_HOLD - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(P_LOCK_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     owner;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [IDX_W-1:0]     issue_owner;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [P_NUM_REQ-1:0] owner_mask;
  logic                 others_valid;
  logic                 accept;
  logic [IDX_W-1:0]     acc_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= P_NUM_REQ) cand = cand - P_NUM_REQ;
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
  end

  assign others_valid = |(req_valid & ~owner_mask);

  always_comb begin
    req_ready = '0;
    if (state == ST_LOCKED) begin
      req_ready = req_valid & owner_mask;
    end else if (win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign accept  = |req_ready;
  assign acc_idx = (state == ST_LOCKED) ? owner : win_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prot_enable <= 1'b0;
      prot_r0w1   <= 1'b0;
      prot_addr   <= '0;
      prot_wdata  <= '0;
      issue_owner <= '0;
      req_done    <= '0;
      req_rdata   <= '0;
      state       <= ST_UNLOCKED;
      ptr         <= '0;
      owner       <= '0;
      hold_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      prot_enable <= accept;
      if (accept) begin
        prot_r0w1   <= req_r0w1[acc_idx];
        prot_addr   <= req_addr[acc_idx];
        prot_wdata  <= req_wdata[acc_idx];
        issue_owner <= acc_idx;
      end

      // Completion stage: read data is sampled while the strobe is on the bus.
      req_done <= '0;
      if (prot_enable) begin
        req_done[issue_owner] <= 1'b1;
        if (!prot_r0w1) req_rdata <= prot_rdata;
      end

      if (state == ST_UNLOCKED) begin
        if (accept) begin
          ptr <= next_idx(win_idx);
          if (req_lock[win_idx]) begin
            state    <= ST_LOCKED;
            owner    <= win_idx;
            hold_cnt <= HOLD_W'(1);
            idle_cnt <= '0;
          end
        end
      end else begin
        if (accept) begin
          idle_cnt <= '0;
          if (!req_lock[owner] || (hold_cnt == HOLD_LAST && others_valid)) begin
            state <= ST_UNLOCKED;
            ptr   <= next_idx(owner);
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          state    <= ST_UNLOCKED;
          ptr      <= next_idx(owner);
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sn_prot_arbiter.sv
`default_nettype none
// tb_sn_prot_arbiter -- scoreboard bench: directed scenarios plus random traffic against
// a rule-level model of arbitration, locking and the two-stage bus pipeline. Rev 1.0
module tb_sn_prot_arbiter;

  localparam int N        = 3;
  localparam int AW       = 7;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;
  localparam int TIMEOUT  = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_lock;
  logic [N-1:0]         req_r0w1;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         req_done;
  logic [DW-1:0]        req_rdata;
  logic                 prot_enable;
  logic                 prot_r0w1;
  logic [AW-1:0]        prot_addr;
  logic [DW-1:0]        prot_wdata;
  logic [DW-1:0]        prot_rdata;

  sn_prot_arbiter #(
    .P_NUM_REQ(N), .P_ADDR_BW(AW), .P_DATA_BW(DW),
    .P_MAX_HOLD(MAX_HOLD), .P_LOCK_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_lock(req_lock), .req_r0w1(req_r0w1),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_done(req_done), .req_rdata(req_rdata),
    .prot_enable(prot_enable), .prot_r0w1(prot_r0w1), .prot_addr(prot_addr),
    .prot_wdata(prot_wdata), .prot_rdata(prot_rdata)
  );

  always #5 clk = ~clk;

  // Network register file stand-in: read data is a fixed function of the address.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return {1'b0, a} ^ 8'hA6;
  endfunction
  assign prot_rdata = rd_model(prot_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int           cyc;
    logic         r0w1;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  typedef struct {
    int           cyc;
    int           owner;
    logic [DW-1:0] rdata;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];
  int    grants[$];
  int    exp_g[$];

  // Reference model state
  bit            m_locked;
  int            m_owner, m_ptr, m_hold, m_idle;
  logic [DW-1:0] m_last_rd;

  task automatic model_reset();
    m_locked  = 1'b0;
    m_owner   = 0;
    m_ptr     = 0;
    m_hold    = 0;
    m_idle    = 0;
    m_last_rd = '0;
    bus_q.delete();
    done_q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] lk, output int g);
    bit others;
    g      = -1;
    others = 1'b0;
    if (m_locked) begin
      if (v[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    for (int i = 0; i < N; i++) if (i != m_owner && v[i]) others = 1'b1;
    if (m_locked) begin
      if (g >= 0) begin
        m_idle = 0;
        if (!lk[g] || (m_hold == MAX_HOLD - 1 && others)) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
        end else if (m_hold < MAX_HOLD - 1) begin
          m_hold++;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % N;
        end
      end
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (lk[g]) begin
        m_locked = 1'b1;
        m_owner  = g;
        m_hold   = 1;
        m_idle   = 0;
      end
    end
  endtask

  // One clock cycle of stimulus: entered and left at posedge+1.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] lk, input logic [N-1:0] w);
    int           g;
    logic [N-1:0] exp_rdy;
    bus_t         b;
    done_t        d;
    req_valid = v;
    req_lock  = lk;
    req_r0w1  = w;
    #3;
    model_step(v, lk, g);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      b.cyc   = cyc + 1;
      b.r0w1  = w[g];
      b.addr  = req_addr[g];
      b.wdata = req_wdata[g];
      bus_q.push_back(b);
      if (!w[g]) m_last_rd = rd_model(req_addr[g]);
      d.cyc   = cyc + 2;
      d.owner = g;
      d.rdata = m_last_rd;
      done_q.push_back(d);
      grants.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = AW'($urandom);
      req_wdata[i] = DW'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic check_grants(input string name, input int exp[$]);
    check({name, "_count"}, grants.size(), exp.size());
    foreach (exp[i]) if (i < grants.size()) check(name, grants[i], exp[i]);
  endtask

  // Monitor: compares bus strobes and completions against the scoreboard queues.
  always @(negedge clk) begin
    logic          exp_en;
    logic [N-1:0]  exp_done;
    logic [DW-1:0] exp_rd;
    exp_en = (bus_q.size() > 0) && (bus_q[0].cyc == cyc);
    check("prot_enable", 32'(prot_enable), 32'(exp_en));
    if (exp_en) begin
      if (prot_enable) begin
        check("prot_r0w1", 32'(prot_r0w1), 32'(bus_q[0].r0w1));
        check("prot_addr", 32'(prot_addr), 32'(bus_q[0].addr));
        if (bus_q[0].r0w1) check("prot_wdata", 32'(prot_wdata), 32'(bus_q[0].wdata));
      end
      void'(bus_q.pop_front());
    end
    exp_done = '0;
    exp_rd   = '0;
    if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
      exp_done[done_q[0].owner] = 1'b1;
      exp_rd = done_q[0].rdata;
    end
    check("req_done", 32'(req_done), 32'(exp_done));
    if (exp_done != '0) begin
      if (req_done == exp_done) check("req_rdata", 32'(req_rdata), 32'(exp_rd));
      void'(done_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_wait;
    rst       = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_r0w1  = '0;
    req_addr  = '0;
    req_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    check("rst_prot_enable", 32'(prot_enable), 0);
    check("rst_prot_r0w1",   32'(prot_r0w1), 0);
    check("rst_prot_addr",   32'(prot_addr), 0);
    check("rst_prot_wdata",  32'(prot_wdata), 0);
    check("rst_req_done",    32'(req_done), 0);
    check("rst_req_rdata",   32'(req_rdata), 0);
    check("rst_req_ready",   32'(req_ready), 0);
    @(posedge clk);
    #1;

    // Single read from requester 0
    req_addr[0] = 7'h05;
    step(3'b001, 3'b000, 3'b000);
    check("rd_bus_enable", 32'(prot_enable), 1);
    check("rd_bus_addr",   32'(prot_addr), 32'h05);
    check("rd_bus_r0w1",   32'(prot_r0w1), 0);
    step(3'b000, 3'b000, 3'b000);
    check("rd_done",  32'(req_done), 32'b001);
    check("rd_rdata", 32'(req_rdata), 32'hA3);
    step(3'b000, 3'b000, 3'b000);

    // Fair alternation right after reset
    do_reset(1);
    grants.delete();
    for (int i = 0; i < 6; i++) begin
      rand_payload();
      step(3'b011, 3'b000, 3'b111);
    end
    exp_g = '{0, 1, 0, 1, 0, 1};
    check_grants("alternate", exp_g);

    // Requester 1 locks for a three-write sequence while requester 0 waits
    step(3'b001, 3'b000, 3'b111);
    grants.delete();
    step(3'b011, 3'b010, 3'b111);
    step(3'b011, 3'b010, 3'b111);
    step(3'b011, 3'b000, 3'b111);
    step(3'b001, 3'b000, 3'b111);
    exp_g = '{1, 1, 1, 0};
    check_grants("lock_seq", exp_g);

    // Hold limit forces requester 0 to give way after MAX_HOLD grants
    step(3'b010, 3'b000, 3'b111);
    grants.delete();
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      step(3'b011, 3'b001, 3'b111);
    end
    exp_g = '{0, 0, 0, 0, 1};
    check_grants("hold_limit", exp_g);

    // Idle timeout of a locked owner
    step(3'b001, 3'b001, 3'b111);
    grants.delete();
    n_wait = 0;
    while (grants.size() == 0 && n_wait < TIMEOUT + 8) begin
      step(3'b010, 3'b000, 3'b111);
      if (grants.size() == 0) n_wait++;
    end
    check("timeout_wait", n_wait, TIMEOUT);
    exp_g = '{1};
    check_grants("timeout_grant", exp_g);

    // Reset the cycle after a read acceptance
    step(3'b001, 3'b000, 3'b000);
    do_reset(1);
    #3;
    check("rst_mid_enable", 32'(prot_enable), 0);
    check("rst_mid_done",   32'(req_done), 0);
    @(posedge clk);
    #1;
    grants.delete();
    step(3'b011, 3'b000, 3'b111);
    exp_g = '{0};
    check_grants("post_reset_grant", exp_g);

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      logic [N-1:0] v, lk, w;
      rand_payload();
      for (int i = 0; i < N; i++) begin
        v[i]  = ($urandom_range(0, 9) < 6);
        lk[i] = ($urandom_range(0, 9) < 4);
        w[i]  = 1'($urandom_range(0, 1));
      end
      step(v, lk, w);
    end
    for (int i = 0; i < 4; i++) step(3'b000, 3'b000, 3'b000);
    check("bus_q_drained",  bus_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sn_prot_arbiter.md
Name: sn_prot_arbiter

Overview:
Arbitrates the single-register protocol bus (prot_enable/prot_r0w1/prot_addr/prot_wdata/prot_rdata) of sn_network between several requesters, e.g. the UART protocol manager and an on-chip stimulus/debug sequencer.
- Arbitration is round-robin, with an optional bus lock for atomic multi-register sequences.
- Lock is bounded by a hold limit and an idle timeout.
- Drives the network's protocol inputs through a registered stage and routes read data back to the owning requester.

Parameters:
P_NUM_REQ, 2, number of requesters (>=2).
P_ADDR_BW, 7, protocol address width.
P_DATA_BW, 8, protocol data width.
P_MAX_HOLD, 16, max consecutive locked transactions before the lock is forcibly released.
P_LOCK_TIMEOUT, 32, idle cycles of a locked owner before the lock is released.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-low reset.
req_valid  in  [P_NUM_REQ]  requester has a transaction.
req_lock  in  [P_NUM_REQ]  keep ownership after this transaction.
req_r0w1  in  [P_NUM_REQ]  0=read, 1=write.
req_addr  in  [P_NUM_REQ][P_ADDR_BW]  register address.
req_wdata  in  [P_NUM_REQ][P_DATA_BW]  write data.
req_ready  out  [P_NUM_REQ]  transaction accepted this cycle (one-hot or zero).
req_done  out  [P_NUM_REQ]  one-cycle completion pulse to the issuing requester.
req_rdata  out  P_DATA_BW  read data; valid with req_done for reads.
prot_enable  out  1  bus strobe to network.
prot_r0w1  out  1  bus direction.
prot_addr  out  P_ADDR_BW  bus address.
prot_wdata  out  P_DATA_BW  bus write data.
prot_rdata  in  P_DATA_BW  network read data, valid combinationally while prot_enable=1.

Behaviour:
- Reset (rst=0 at a clk edge) clears all of the following:
  - Outputs: prot_enable, prot_r0w1, prot_addr, prot_wdata, req_done, req_rdata all 0.
  - Internal state: rr pointer=0, state=UNLOCKED, hold_cnt=0, idle_cnt=0, pending transactions dropped (no req_done).
- req_ready is combinational from req_valid, state and pointer. A transaction is accepted when req_valid[i] & req_ready[i].
- UNLOCKED arbitration:
  - Grant goes to the first valid requester starting at index ptr, wrapping modulo P_NUM_REQ.
  - On acceptance, ptr <= winner+1 (wrap).
  - No valid requesters -> nothing granted, ptr unchanged.
- Throughput is one accepted transaction per cycle, back-to-back; there is no bus back-pressure.
- Pipeline for a transaction accepted in cycle N:
  - Cycle N+1: prot_enable=1 with the captured r0w1/addr/wdata. For reads, prot_rdata is registered at the end of this cycle.
  - Cycle N+2: req_done[owner]=1. req_rdata = captured data for reads; holds its previous value for writes.
  - prot_enable=0 in any cycle following a cycle with no acceptance.
- Lock state machine, states UNLOCKED and LOCKED(owner):
  - UNLOCKED -> LOCKED(i): accepted transaction from i with req_lock[i]=1. Set hold_cnt=1, idle_cnt=0.
  - While LOCKED, only the owner can be granted; the other requesters see req_ready=0.
  - Owner accepted with req_lock=1:
    - If hold_cnt == P_MAX_HOLD-1 and any other requester is valid: -> UNLOCKED, ptr = owner+1.
    - Otherwise hold_cnt++ and remain LOCKED. hold_cnt saturates at P_MAX_HOLD-1 while no other requester is valid.
  - Owner accepted with req_lock=0: -> UNLOCKED, ptr = owner+1.
  - Owner not valid: idle_cnt++. When idle_cnt reaches P_LOCK_TIMEOUT: -> UNLOCKED, ptr = owner+1, with arbitration resuming the following cycle. Any owner acceptance resets idle_cnt=0.
- Release conditions are evaluated on the accepting edge. The next cycle's grant uses the new state.
- A requester deasserting req_valid without acceptance is legal; nothing is issued.

Test Plan:
- Single requester 0 read addr 0x05, network returns 0xA3:
  - Accept at cycle N; prot_enable=1, addr=0x05, r0w1=0 at N+1.
  - req_done[0]=1 and req_rdata=0xA3 at N+2.
- Both requesters continuously valid with writes, no lock, 6 cycles after reset:
  - Grants alternate 0,1,0,1,0,1.
  - prot_enable high on 6 consecutive cycles; each req_done lands on its issuer 2 cycles after acceptance.
- Requester 1 issues 3 writes with lock=1,1,0 while requester 0 is valid throughout:
  - Grants 1,1,1, then 0.
  - req_ready[0]=0 during the lock.
- P_MAX_HOLD=4: requester 0 streams lock=1 while requester 1 is valid:
  - Requester 0 gets exactly 4 grants, then requester 1 is granted on the next cycle.
- P_LOCK_TIMEOUT=32: requester 0 locks then goes idle while requester 1 is valid:
  - req_ready[1] stays 0 for 32 cycles, then asserts.
- rst=0 on the cycle after a read acceptance:
  - prot_enable=0 and no req_done pulse.
  - After reset, requesters 0 and 1 both valid -> requester 0 is granted first.
